// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, instruction field positions, ALU operand-B select codes
// and default datapath widths.
package cpu_pkg;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned ADDR_W_DEF = 8;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_LW   = 3'b100,
        OP_SW   = 3'b101,
        OP_BEQ  = 3'b110,
        OP_HALT = 3'b111
    } opcode_e;

    // Instruction layout: opcode[15:13] rd[12:11] rs1[10:9] rs2[8:7] imm[6:0]
    localparam int unsigned OPC_LSB = 13;
    localparam int unsigned OPC_W   = 3;
    localparam int unsigned RD_LSB  = 11;
    localparam int unsigned RS1_LSB = 9;
    localparam int unsigned RS2_LSB = 7;
    localparam int unsigned REG_W   = 2;
    localparam int unsigned IMM_W   = 7;

    typedef enum logic [1:0] {
        SRCB_REG = 2'b00,
        SRCB_ONE = 2'b01,
        SRCB_IMM = 2'b10,
        SRCB_BR  = 2'b11
    } srcb_e;

endpackage

// File: rtl/datapath_regs_if.sv
// Control-strobe and datapath bus between the control unit / memory / ALU and the
// datapath register set. The slave modport is the datapath side.
interface datapath_regs_if
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
);

    logic              PCWrite;
    logic              PCWriteCond;
    logic              IRWrite;
    logic              ALUSrcA;
    logic [1:0]        ALUSrcB;
    logic              MemToReg;
    logic              IorD;
    logic              zero_flag;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] rf_rdata1;
    logic [DATA_W-1:0] rf_rdata2;

    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] rf_wdata;
    logic [2:0]        opcode;
    logic [1:0]        rd;
    logic [1:0]        rs1;
    logic [1:0]        rs2;
    logic [DATA_W-1:0] imm_ext;
    logic [ADDR_W-1:0] pc_out;

    modport master (
        output PCWrite, PCWriteCond, IRWrite, ALUSrcA, ALUSrcB, MemToReg, IorD,
        output zero_flag, alu_result, mem_rdata, rf_rdata1, rf_rdata2,
        input  alu_a, alu_b, mem_addr, mem_wdata, rf_wdata,
        input  opcode, rd, rs1, rs2, imm_ext, pc_out
    );

    modport slave (
        input  PCWrite, PCWriteCond, IRWrite, ALUSrcA, ALUSrcB, MemToReg, IorD,
        input  zero_flag, alu_result, mem_rdata, rf_rdata1, rf_rdata2,
        output alu_a, alu_b, mem_addr, mem_wdata, rf_wdata,
        output opcode, rd, rs1, rs2, imm_ext, pc_out
    );

endinterface

// File: rtl/perf_counters.sv
// Free-running cycle counter and fetched-instruction counter, both wrapping at 2^32.
// Compiled only when PERF_CNT_EN is defined.
`ifdef PERF_CNT_EN
module perf_counters (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ir_write,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instr_cnt
);

    logic [31:0] cycle_q, cycle_d;
    logic [31:0] instr_q, instr_d;

    always_comb begin
        cycle_d = cycle_q + 32'd1;
        instr_d = instr_q;
        if (ir_write) begin
            instr_d = instr_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle_q <= '0;
            instr_q <= '0;
        end else begin
            cycle_q <= cycle_d;
            instr_q <= instr_d;
        end
    end

    assign cycle_cnt = cycle_q;
    assign instr_cnt = instr_q;

endmodule
`endif

// File: rtl/datapath_regs.sv
// Multicycle datapath register set (PC, IR, MDR, A, B, ALUOut) with operand/address muxing.
// Build option: define PERF_CNT_EN to add the cycle_cnt / instr_cnt counter outputs.
module datapath_regs
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic clk,
    input  logic reset_n,
    datapath_regs_if.slave bus
`ifdef PERF_CNT_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instr_cnt
`endif
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] mdr_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] alu_out_q;

    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] pc_ext;

    // PCWrite wins over a conditional branch; the branch target is last cycle's ALUOut.
    always_comb begin
        pc_d = pc_q;
        if (bus.PCWrite) begin
            pc_d = bus.alu_result[ADDR_W-1:0];
        end else if (bus.PCWriteCond && bus.zero_flag) begin
            pc_d = alu_out_q[ADDR_W-1:0];
        end
    end

    always_comb begin
        ir_d = ir_q;
        if (bus.IRWrite) begin
            ir_d = bus.mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q      <= '0;
            ir_q      <= '0;
            mdr_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_out_q <= '0;
        end else begin
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            mdr_q     <= bus.mem_rdata;
            a_q       <= bus.rf_rdata1;
            b_q       <= bus.rf_rdata2;
            alu_out_q <= bus.alu_result;
        end
    end

    always_comb begin
        imm_ext = {{(DATA_W - IMM_W){ir_q[IMM_W-1]}}, ir_q[IMM_W-1:0]};
        pc_ext  = {{(DATA_W - ADDR_W){1'b0}}, pc_q};

        bus.alu_a = bus.ALUSrcA ? a_q : pc_ext;

        bus.alu_b = imm_ext;
        case (srcb_e'(bus.ALUSrcB))
            SRCB_REG: bus.alu_b = b_q;
            SRCB_ONE: bus.alu_b = {{(DATA_W - 1){1'b0}}, 1'b1};
            SRCB_IMM: bus.alu_b = imm_ext;
            SRCB_BR:  bus.alu_b = imm_ext;
            default:  bus.alu_b = imm_ext;
        endcase

        bus.mem_addr  = bus.IorD ? bus.alu_result[ADDR_W-1:0] : pc_q;
        bus.mem_wdata = b_q;
        bus.rf_wdata  = bus.MemToReg ? mdr_q : alu_out_q;

        bus.opcode  = ir_q[OPC_LSB +: OPC_W];
        bus.rd      = ir_q[RD_LSB +: REG_W];
        bus.rs1     = ir_q[RS1_LSB +: REG_W];
        bus.rs2     = ir_q[RS2_LSB +: REG_W];
        bus.imm_ext = imm_ext;
        bus.pc_out  = pc_q;
    end

`ifdef PERF_CNT_EN
    perf_counters u_perf_counters (
        .clk       (clk),
        .reset_n   (reset_n),
        .ir_write  (bus.IRWrite),
        .cycle_cnt (cycle_cnt),
        .instr_cnt (instr_cnt)
    );
`endif

endmodule

// File: tb/tb_datapath_regs.sv
// Bench for datapath_regs: directed vectors with literal expectations plus a per-cycle
// comparison against an arithmetic model of the register set.
module tb_datapath_regs;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 8;

    logic clk = 1'b0;
    logic reset_n;

    datapath_regs_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

`ifdef PERF_CNT_EN
    logic [31:0] cycle_cnt;
    logic [31:0] instr_cnt;
`endif

    datapath_regs #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
`ifdef PERF_CNT_EN
        ,
        .cycle_cnt (cycle_cnt),
        .instr_cnt (instr_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: what each architectural register must hold.
    int unsigned m_pc;
    logic [15:0] m_ir, m_mdr, m_a, m_b, m_alu_out;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_pc      <= 0;
            m_ir      <= '0;
            m_mdr     <= '0;
            m_a       <= '0;
            m_b       <= '0;
            m_alu_out <= '0;
        end else begin
            if (bus.PCWrite) m_pc <= int'(bus.alu_result) % 256;
            else if (bus.PCWriteCond && bus.zero_flag) m_pc <= int'(m_alu_out) % 256;
            if (bus.IRWrite) m_ir <= bus.mem_rdata;
            m_mdr     <= bus.mem_rdata;
            m_a       <= bus.rf_rdata1;
            m_b       <= bus.rf_rdata2;
            m_alu_out <= bus.alu_result;
        end
    end

    int          e_imm;
    logic [15:0] e_imm16, e_alu_a, e_alu_b, e_rf_wdata;
    int unsigned e_addr;

    always @(negedge clk) begin
        if (chk_en) begin
            e_imm = int'(m_ir) % 128;
            if (e_imm >= 64) e_imm = e_imm - 128;
            e_imm16    = 16'(e_imm);
            e_alu_a    = bus.ALUSrcA ? m_a : 16'(m_pc);
            e_alu_b    = (bus.ALUSrcB == 2'd0) ? m_b : (bus.ALUSrcB == 2'd1) ? 16'd1 : e_imm16;
            e_addr     = bus.IorD ? int'(bus.alu_result) % 256 : m_pc;
            e_rf_wdata = bus.MemToReg ? m_mdr : m_alu_out;
            chk("cyc pc_out", 32'(bus.pc_out), 32'(m_pc));
            chk("cyc opcode", 32'(bus.opcode), 32'(m_ir / 16'd8192));
            chk("cyc rd", 32'(bus.rd), 32'((m_ir / 16'd2048) % 16'd4));
            chk("cyc rs1", 32'(bus.rs1), 32'((m_ir / 16'd512) % 16'd4));
            chk("cyc rs2", 32'(bus.rs2), 32'((m_ir / 16'd128) % 16'd4));
            chk("cyc imm_ext", 32'(bus.imm_ext), 32'(e_imm16));
            chk("cyc alu_a", 32'(bus.alu_a), 32'(e_alu_a));
            chk("cyc alu_b", 32'(bus.alu_b), 32'(e_alu_b));
            chk("cyc mem_addr", 32'(bus.mem_addr), 32'(e_addr));
            chk("cyc mem_wdata", 32'(bus.mem_wdata), 32'(m_b));
            chk("cyc rf_wdata", 32'(bus.rf_wdata), 32'(e_rf_wdata));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.PCWrite     = 1'b0;
        bus.PCWriteCond = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.ALUSrcA     = 1'b0;
        bus.ALUSrcB     = 2'b00;
        bus.MemToReg    = 1'b0;
        bus.IorD        = 1'b0;
        bus.zero_flag   = 1'b0;
    endtask

    initial begin
        reset_n        = 1'b0;
        idle();
        bus.alu_result = '0;
        bus.mem_rdata  = '0;
        bus.rf_rdata1  = '0;
        bus.rf_rdata2  = '0;
        repeat (2) step();
        chk("rst pc_out", 32'(bus.pc_out), 32'h0);
        chk("rst opcode", 32'(bus.opcode), 32'h0);
        chk("rst imm_ext", 32'(bus.imm_ext), 32'h0);
        chk("rst mem_addr", 32'(bus.mem_addr), 32'h0);
        chk("rst rf_wdata", 32'(bus.rf_wdata), 32'h0);
        reset_n = 1'b1;
        chk_en  = 1'b1;

        // Fetch: IR takes the old-PC word while PC advances.
        bus.mem_rdata  = 16'h0A85;
        bus.alu_result = 16'h0001;
        bus.IRWrite    = 1'b1;
        bus.PCWrite    = 1'b1;
        step();
        idle();
        chk("fetch opcode", 32'(bus.opcode), 32'h0);
        chk("fetch rd", 32'(bus.rd), 32'h1);
        chk("fetch rs1", 32'(bus.rs1), 32'h1);
        chk("fetch rs2", 32'(bus.rs2), 32'h1);
        chk("fetch imm_ext", 32'(bus.imm_ext), 32'h0005);
        chk("fetch pc", 32'(bus.pc_out), 32'h01);

        // Branch: ALUOut holds 0x12 before each PCWriteCond edge.
        bus.alu_result = 16'h0012;
        step();
        bus.PCWriteCond = 1'b1;
        bus.zero_flag   = 1'b0;
        step();
        chk("br not taken pc", 32'(bus.pc_out), 32'h01);
        bus.zero_flag = 1'b1;
        step();
        chk("br taken pc", 32'(bus.pc_out), 32'h12);
        bus.PCWrite    = 1'b1;
        bus.alu_result = 16'h0007;
        step();
        idle();
        chk("pcwrite priority pc", 32'(bus.pc_out), 32'h07);

        // Load path
        bus.IorD       = 1'b1;
        bus.alu_result = 16'h0040;
        #1;
        chk("load mem_addr", 32'(bus.mem_addr), 32'h40);
        bus.mem_rdata = 16'hBEEF;
        step();
        bus.MemToReg = 1'b1;
        #1;
        chk("load rf_wdata mdr", 32'(bus.rf_wdata), 32'hBEEF);
        bus.MemToReg = 1'b0;
        #1;
        chk("rf_wdata aluout", 32'(bus.rf_wdata), 32'h0040);
        idle();

        // Sign extension and operand muxes
        bus.IRWrite   = 1'b1;
        bus.mem_rdata = 16'h007F;
        bus.rf_rdata1 = 16'hA5A5;
        bus.rf_rdata2 = 16'h1234;
        step();
        idle();
        chk("sext imm_ext", 32'(bus.imm_ext), 32'hFFFF);
        bus.ALUSrcB = 2'b10;
        #1;
        chk("srcb imm alu_b", 32'(bus.alu_b), 32'hFFFF);
        bus.ALUSrcB = 2'b01;
        #1;
        chk("srcb one alu_b", 32'(bus.alu_b), 32'h0001);
        bus.ALUSrcB = 2'b00;
        #1;
        chk("srcb reg alu_b", 32'(bus.alu_b), 32'h1234);
        chk("mem_wdata", 32'(bus.mem_wdata), 32'h1234);
        bus.ALUSrcA = 1'b1;
        #1;
        chk("srca a alu_a", 32'(bus.alu_a), 32'hA5A5);
        bus.ALUSrcA = 1'b0;
        #1;
        chk("srca pc alu_a", 32'(bus.alu_a), 32'h0007);

        // PC wrap
        step();
        bus.PCWrite    = 1'b1;
        bus.alu_result = 16'h0100;
        step();
        idle();
        chk("wrap pc", 32'(bus.pc_out), 32'h00);

        // Random traffic against the model
        for (int i = 0; i < 40; i++) begin
            bus.PCWrite     = 1'($urandom);
            bus.PCWriteCond = 1'($urandom);
            bus.IRWrite     = 1'($urandom);
            bus.ALUSrcA     = 1'($urandom);
            bus.ALUSrcB     = 2'($urandom);
            bus.MemToReg    = 1'($urandom);
            bus.IorD        = 1'($urandom);
            bus.zero_flag   = 1'($urandom);
            bus.alu_result  = 16'($urandom);
            bus.mem_rdata   = 16'($urandom);
            bus.rf_rdata1   = 16'($urandom);
            bus.rf_rdata2   = 16'($urandom);
            step();
        end
        idle();

        // Asynchronous reset mid-instruction
        bus.PCWrite    = 1'b1;
        bus.alu_result = 16'h003C;
        bus.IRWrite    = 1'b1;
        bus.mem_rdata  = 16'hFFFF;
        step();
        idle();
        bus.MemToReg = 1'b1;
        bus.ALUSrcA  = 1'b1;
        #2;
        chk("pre-reset pc", 32'(bus.pc_out), 32'h3C);
        reset_n = 1'b0;
        #1;
        chk("async rst pc", 32'(bus.pc_out), 32'h00);
        chk("async rst opcode", 32'(bus.opcode), 32'h0);
        chk("async rst imm_ext", 32'(bus.imm_ext), 32'h0);
        chk("async rst mem_addr", 32'(bus.mem_addr), 32'h00);
        chk("async rst rf_wdata", 32'(bus.rf_wdata), 32'h0);
        chk("async rst alu_a", 32'(bus.alu_a), 32'h0);
        reset_n = 1'b1;
        idle();
        chk("refetch addr", 32'(bus.mem_addr), 32'h00);

        // Ten cycles out of reset with three fetch pulses
        for (int i = 0; i < 10; i++) begin
            bus.IRWrite = (i == 1 || i == 4 || i == 7);
            step();
        end
        idle();
`ifdef PERF_CNT_EN
        chk("cycle_cnt", cycle_cnt, 32'd10);
        chk("instr_cnt", instr_cnt, 32'd3);
`endif
        step();
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
